// File: rtl/deserializer_out.sv
// Serial word-link receiver: hunts comma alignment, then assembles {w3,w2,w1} frames.
// Optional saturating error counter on err_cnt_o when DESER_ERR_CNT_EN is defined.
module deserializer_out #(
  parameter int LOCK_COMMAS = 2,
  parameter int LOSS_ERRS   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  output logic [26:0] data_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        err_o
`ifdef DESER_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt_o
`endif
);

  localparam logic [8:0] COMMA = 9'h13C;
  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int MW = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t          state, state_n;
  logic [8:0]      sr, sr_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [CW-1:0]   comma_cnt, comma_cnt_n, comma_inc;
  logic [MW-1:0]   miss, miss_n, miss_inc;
  logic [1:0]      wcnt, wcnt_n;
  logic            exp_comma, exp_comma_n;
  logic [8:0]      w1, w1_n, w2, w2_n;
  logic [26:0]     data_n;
  logic            valid_n, err_n, locked_n;
  logic            is_comma, boundary;

`ifdef DESER_ERR_CNT_EN
  logic [7:0]      err_cnt, err_cnt_n;
`endif

  assign is_comma  = (sr == COMMA);
  assign boundary  = (bit_cnt == 4'd8);
  assign comma_inc = comma_cnt + 1'b1;
  assign miss_inc  = miss + 1'b1;

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path leaves one unassigned (no latches).
    state_n     = state;
    sr_n        = {data_i, sr[8:1]};
    bit_cnt_n   = boundary ? 4'd0 : bit_cnt + 4'd1;
    comma_cnt_n = comma_cnt;
    miss_n      = miss;
    wcnt_n      = wcnt;
    exp_comma_n = exp_comma;
    w1_n        = w1;
    w2_n        = w2;
    data_n      = data_o;
    valid_n     = 1'b0;
    err_n       = 1'b0;

    case (state)
      ST_HUNT: begin
        if (is_comma) begin
          bit_cnt_n   = 4'd0;
          comma_cnt_n = CW'(1);
          state_n     = (LOCK_COMMAS == 1) ? ST_LOCKED : ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_n = comma_inc;
            if (comma_inc == CW'(LOCK_COMMAS)) state_n = ST_LOCKED;
          end else begin
            comma_cnt_n = '0;
            state_n     = ST_HUNT;
          end
        end
      end

      ST_LOCKED: begin
        if (boundary) begin
          if (is_comma) begin
            // A comma mid-frame means the partial frame is lost.
            err_n       = (wcnt != 2'd0);
            wcnt_n      = 2'd0;
            exp_comma_n = 1'b0;
            miss_n      = '0;
          end else if (exp_comma) begin
            err_n = 1'b1;
            if (miss_inc == MW'(LOSS_ERRS)) begin
              state_n     = ST_HUNT;
              wcnt_n      = 2'd0;
              exp_comma_n = 1'b0;
              miss_n      = '0;
              comma_cnt_n = '0;
            end else begin
              miss_n = miss_inc;
            end
          end else begin
            case (wcnt)
              2'd0: begin
                w1_n   = sr;
                wcnt_n = 2'd1;
              end
              2'd1: begin
                w2_n   = sr;
                wcnt_n = 2'd2;
              end
              default: begin
                data_n      = {sr, w2, w1};
                valid_n     = 1'b1;
                wcnt_n      = 2'd0;
                exp_comma_n = 1'b1;
              end
            endcase
          end
        end
      end

      default: state_n = ST_HUNT;
    endcase

    locked_n = (state_n == ST_LOCKED);

`ifdef DESER_ERR_CNT_EN
    err_cnt_n = (err_n && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
`endif
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    if (rst_i) begin
      state     <= ST_HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      miss      <= '0;
      wcnt      <= '0;
      exp_comma <= 1'b0;
      w1        <= '0;
      w2        <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      locked_o  <= 1'b0;
`ifdef DESER_ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      bit_cnt   <= bit_cnt_n;
      comma_cnt <= comma_cnt_n;
      miss      <= miss_n;
      wcnt      <= wcnt_n;
      exp_comma <= exp_comma_n;
      w1        <= w1_n;
      w2        <= w2_n;
      data_o    <= data_n;
      valid_o   <= valid_n;
      err_o     <= err_n;
      locked_o  <= locked_n;
`ifdef DESER_ERR_CNT_EN
      err_cnt   <= err_cnt_n;
`endif
    end
  end

`ifdef DESER_ERR_CNT_EN
  assign err_cnt_o = err_cnt;
`endif

endmodule

// File: tb/tb_deserializer_out.sv
// Directed self-checking bench for deserializer_out: lock, framing, errors, lock loss, reset.
// Build with +define+DESER_ERR_CNT_EN to also check the error counter.
module tb_deserializer_out;

  localparam logic [8:0] COMMA = 9'h13C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [26:0] data;
  logic        valid, locked, err;
`ifdef DESER_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int lock_cyc = -1;
  logic [26:0] last_data = '0;

  deserializer_out dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .data_i   (din),
    .data_o   (data),
    .valid_o  (valid),
    .locked_o (locked),
    .err_o    (err)
`ifdef DESER_ERR_CNT_EN
    ,
    .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid   = n_valid + 1;
      last_data = data;
    end
    if (err) n_err = n_err + 1;
    if (locked && lock_cyc < 0) lock_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [8:0] w);
    for (int i = 0; i < 9; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int v0, e0, start;
  logic [26:0] exp_a, exp_b, exp_c, exp_d;

  initial begin
    exp_a = {9'h033, 9'h122, 9'h011};
    exp_b = {9'h0F0, 9'h1A5, 9'h055};
    exp_c = {9'h0C3, 9'h102, 9'h07E};
    exp_d = {9'h1EE, 9'h044, 9'h089};

    // Reset state
    do_reset();
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_err", 32'(err), 32'h0);
`ifdef DESER_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
`endif

    // Lock on idle commas: 2nd comma's last bit at S+17, locked visible at S+19
    lock_cyc = -1;
    start = cyc;
    repeat (4) send_word(COMMA);
    check("lock_latency", 32'(lock_cyc - start), 32'd19);
    check("lock_locked", 32'(locked), 32'h1);
    check("lock_no_valid", 32'(n_valid), 32'd0);
    check("lock_no_err", 32'(n_err), 32'd0);

    // One clean frame
    v0 = n_valid; e0 = n_err;
    send_word(COMMA);
    send_word(9'h011); send_word(9'h122); send_word(9'h033);
    send_word(COMMA); send_word(COMMA);
    check("frame_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("frame_data", 32'(last_data), 32'(exp_a));
    check("frame_no_err", 32'(n_err - e0), 32'd0);

    // comma, w1, comma -> one error, no frame; then a full frame recovers
    v0 = n_valid; e0 = n_err;
    send_word(9'h0AA); send_word(COMMA); send_word(COMMA);
    check("short_err_cnt", 32'(n_err - e0), 32'd1);
    check("short_no_valid", 32'(n_valid - v0), 32'd0);
    check("short_locked", 32'(locked), 32'h1);
    send_word(9'h055); send_word(9'h1A5); send_word(9'h0F0);
    send_word(COMMA); send_word(COMMA);
    check("recover_valid", 32'(n_valid - v0), 32'd1);
    check("recover_data", 32'(last_data), 32'(exp_b));

    // Fresh reset, stream starts 4 bits off: must hunt to the true boundary
    do_reset();
    v0 = n_valid; e0 = n_err;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_word(COMMA);
    send_bit(COMMA[0]);
    check("skew_not_locked", 32'(locked), 32'h0);
    for (int i = 1; i < 9; i++) send_bit(COMMA[i]);
    send_word(COMMA);
    check("skew_locked", 32'(locked), 32'h1);
    check("skew_no_valid", 32'(n_valid - v0), 32'd0);
    send_word(9'h07E); send_word(9'h102); send_word(9'h0C3);
    send_bit(1'b1); send_bit(1'b1);
    check("skew_frame_valid", 32'(n_valid - v0), 32'd1);
    check("skew_frame_data", 32'(last_data), 32'(exp_c));
    check("skew_locked_pre_loss", 32'(locked), 32'h1);

    // Frame just completed (sent above, first 2 bits of next word already out):
    // four non-comma words -> four errors, lock lost on the 4th
    for (int i = 2; i < 9; i++) send_bit(1'b1);
    send_word(9'h100); send_word(9'h001); send_word(9'h0FF);
    send_bit(1'b0); send_bit(1'b0);
    check("loss_err_pulses", 32'(n_err - e0), 32'd4);
    check("loss_unlocked", 32'(locked), 32'h0);
    check("loss_no_valid", 32'(n_valid - v0), 32'd1);
`ifdef DESER_ERR_CNT_EN
    check("loss_err_cnt", 32'(err_cnt), 32'd4);
`endif

    // Reset mid-frame after w2
    do_reset();
    v0 = n_valid;
    repeat (3) send_word(COMMA);
    send_word(9'h089); send_word(9'h044); send_word(9'h1EE);
    send_word(COMMA);
    check("pre_rst_valid", 32'(n_valid - v0), 32'd1);
    check("pre_rst_data", 32'(last_data), 32'(exp_d));
    send_word(9'h011); send_word(9'h022);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    rst = 1'b0;
    v0 = n_valid;
    send_word(9'h033); send_word(9'h011); send_word(9'h122); send_word(9'h033);
    send_bit(1'b0); send_bit(1'b0);
    check("post_rst_no_valid", 32'(n_valid - v0), 32'd0);
    check("post_rst_unlocked", 32'(locked), 32'h0);
    repeat (4) send_word(COMMA);
    send_word(9'h011); send_word(9'h122); send_word(9'h033);
    send_word(COMMA);
    check("relock_valid", 32'(n_valid - v0), 32'd1);
    check("relock_data", 32'(last_data), 32'(exp_a));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
